// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared definitions for the SPI register bank: default word and address
// widths, the position of the write flag in a command word, and the FSM
// state encoding used by spi_reg_bank.
// -----------------------------------------------------------------------------
package spi_reg_pkg;

   localparam int DEF_BITS      = 8;
   localparam int DEF_ADDR_BITS = 4;

   // Write flag position in a command word at the default width.  The bank
   // shifts it with BITS so it always sits on the MSB.
   localparam int CMD_WRITE_BIT = DEF_BITS - 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

endpackage : spi_reg_pkg

// File: rtl/spi_reg_file.sv
// -----------------------------------------------------------------------------
// spi_reg_file
// Register storage for the SPI register bank: one synchronous write port,
// one combinational read port and a flat view of every register.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset, clears every register
//   i_wr_en      write enable for one clk
//   i_wr_addr    register index written when i_wr_en is high
//   i_wr_data    data written
//   i_rd_addr    register index presented on o_rd_data
//   o_rd_data    combinational read of register i_rd_addr
//   o_regs_flat  all registers, register i at [i*BITS +: BITS]
// -----------------------------------------------------------------------------
module spi_reg_file
   import spi_reg_pkg::*;
#(
   parameter int BITS      = DEF_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int NUM_REGS  = 2**ADDR_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_wr_en,
   input  logic [ADDR_BITS-1:0]     i_wr_addr,
   input  logic [BITS-1:0]          i_wr_data,
   input  logic [ADDR_BITS-1:0]     i_rd_addr,
   output logic [BITS-1:0]          o_rd_data,
   output logic [NUM_REGS*BITS-1:0] o_regs_flat
);

   logic [BITS-1:0] r_regs [NUM_REGS];

   // NOTE: this storage is a bank of flops that must read back as zero after
   // reset, so it is reset explicitly; a RAM-style array without reset would
   // come up with undefined contents.
   // NOTE: sequential state is assigned with non-blocking (<=) so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data = r_regs[i_rd_addr];
   end

   always_comb begin
      // NOTE: every combinational output gets a default before any loop or
      // branch so no path can leave it unassigned and infer a latch.
      o_regs_flat = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         o_regs_flat[i*BITS +: BITS] = r_regs[i];
      end
   end

endmodule : spi_reg_file

// File: rtl/spi_reg_bank.sv
// -----------------------------------------------------------------------------
// spi_reg_bank
// Register bank sitting behind an SPI slave.  The first word of a frame is a
// command (MSB = 1 write, 0 read; low ADDR_BITS = start address); following
// words are written to, or read back from, the register at the pointer.
//
// Configuration macro: SPI_REG_AUTOINC_EN
//   defined   - pointer advances (mod NUM_REGS) after every data word (burst)
//   undefined - pointer stays on the start address for the whole frame
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   ssel       SPI chip select, active-low (same net as the slave)
//   rx_valid   one-clk pulse: a word was received
//   rx_data    received word, valid from the cycle after rx_valid
//   tx_data    next word to shift out; register at the pointer in READ, else 0
//   wr_strobe  one-clk pulse per completed register write
//   wr_addr    register written at wr_strobe
//   regs_flat  all registers, register i at [i*BITS +: BITS]
// -----------------------------------------------------------------------------
module spi_reg_bank
   import spi_reg_pkg::*;
#(
   parameter int BITS      = DEF_BITS,
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int NUM_REGS  = 2**ADDR_BITS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ssel,
   input  logic                     rx_valid,
   input  logic [BITS-1:0]          rx_data,
   output logic [BITS-1:0]          tx_data,
   output logic                     wr_strobe,
   output logic [ADDR_BITS-1:0]     wr_addr,
   output logic [NUM_REGS*BITS-1:0] regs_flat
);

   // Write flag tracks the MSB when BITS is overridden.
   localparam int WR_BIT = CMD_WRITE_BIT + (BITS - DEF_BITS);

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_word_valid;
   logic [ADDR_BITS-1:0]  r_ptr;
   logic [ADDR_BITS-1:0]  w_ptr_next;
   logic [ADDR_BITS-1:0]  w_ptr_step;
   logic                  w_wr_en;
   logic [BITS-1:0]       w_rd_data;
   logic [BITS-1:0]       r_tx_data;
   logic                  r_wr_strobe;
   logic [ADDR_BITS-1:0]  r_wr_addr;

   // Delayed word pulse: rx_data is only guaranteed one clk after rx_valid.
   // Words arriving with ssel high belong to no frame and are dropped here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_valid <= 1'b0;
      end else begin
         r_word_valid <= rx_valid & ~ssel;
      end
   end

`ifdef SPI_REG_AUTOINC_EN
   assign w_ptr_step = r_ptr + 1'b1;   // wraps naturally at NUM_REGS
`else
   assign w_ptr_step = r_ptr;
`endif

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- FSM: next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (r_word_valid && !ssel) begin
               w_state_next = rx_data[WR_BIT] ? WRITE : READ;
            end
         end
         WRITE, READ: begin
            if (ssel) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // ---------------- FSM: output logic ----------------
   // A data word that lands together with ssel rising is still written;
   // the state logic above takes the FSM back to IDLE on the same edge.
   always_comb begin
      w_ptr_next = r_ptr;
      w_wr_en    = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_word_valid && !ssel) begin
               w_ptr_next = rx_data[ADDR_BITS-1:0];
            end
         end
         WRITE: begin
            if (r_word_valid) begin
               w_wr_en    = 1'b1;
               w_ptr_next = w_ptr_step;
            end
         end
         READ: begin
            if (r_word_valid) begin
               w_ptr_next = w_ptr_step;
            end
         end
         default: ;
      endcase
   end

   // Pointer, write strobe and transmit register.  tx_data is loaded from the
   // next pointer / next state so it settles on the same edge the pointer
   // moves, keeping rx_valid -> tx_data within 2 clk.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_wr_strobe <= 1'b0;
         r_wr_addr   <= '0;
         r_tx_data   <= '0;
      end else begin
         r_ptr       <= w_ptr_next;
         r_wr_strobe <= w_wr_en;
         if (w_wr_en) begin
            r_wr_addr <= r_ptr;
         end
         r_tx_data   <= (w_state_next == READ) ? w_rd_data : '0;
      end
   end

   spi_reg_file #(
      .BITS      (BITS),
      .ADDR_BITS (ADDR_BITS),
      .NUM_REGS  (NUM_REGS)
   ) u_reg_file (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_wr_en     (w_wr_en),
      .i_wr_addr   (r_ptr),
      .i_wr_data   (rx_data),
      .i_rd_addr   (w_ptr_next),
      .o_rd_data   (w_rd_data),
      .o_regs_flat (regs_flat)
   );

   assign tx_data   = r_tx_data;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;

endmodule : spi_reg_bank
